// File: rtl/safety_island_pkg.sv
// Island-wide constants and default register-bus types for the safety island.
package safety_island_pkg;

    // Read data returned to the core when a peripheral never answers.
    localparam logic [31:0] BridgeErrVal = 32'hBADCAB1E;

    // Default 32-bit register-bus request/response layout used by the island.
    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } bridge_reg_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } bridge_reg_rsp_t;

    // Counter width able to hold 0..cycles; at least one bit so a
    // disabled timeout still elaborates cleanly.
    function automatic int unsigned tmo_cnt_width(input int unsigned cycles);
        return (cycles == 0) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/safety_obi_reg_bridge_tmo.sv
// Saturating wait counter for the OBI-to-regbus bridge. expired_o flags the
// cycle in which the counter sits on TimeoutCycles-1; the caller decides
// whether that cycle really times out (a ready in the same cycle wins).
module safety_obi_reg_bridge_tmo
    import safety_island_pkg::*;
#(
    parameter int unsigned TimeoutCycles = 256
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned CntWidth = tmo_cnt_width(TimeoutCycles);

    generate
        if (TimeoutCycles == 0) begin : g_off
            logic w_unused;
            assign w_unused  = ^{clk_i, rst_i, clear_i, enable_i};
            assign expired_o = 1'b0;
        end else begin : g_on
            localparam logic [CntWidth-1:0] CntLast = CntWidth'(TimeoutCycles - 1);
            localparam logic [CntWidth-1:0] CntMax  = CntWidth'(TimeoutCycles);

            logic [CntWidth-1:0] r_cnt;

            // Count waited cycles; clear takes priority, saturate at the top.
            always_ff @(posedge clk_i) begin
                if (rst_i || clear_i) begin
                    r_cnt <= '0;
                end else if (enable_i && (r_cnt != CntMax)) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            assign expired_o = (r_cnt == CntLast);
        end
    endgenerate

endmodule

// File: rtl/safety_obi_reg_bridge.sv
// Responder-side bridge from the safety core OBI data port to the core-local
// register bus. One outstanding request; every grant gets exactly one
// response, either from the peripheral or from the timeout.
module safety_obi_reg_bridge
    import safety_island_pkg::*;
#(
    parameter int unsigned AddrWidth     = 32,
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned TimeoutCycles = 256,
    parameter type         reg_req_t     = safety_island_pkg::bridge_reg_req_t,
    parameter type         reg_rsp_t     = safety_island_pkg::bridge_reg_rsp_t
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   data_req_i,
    output logic                   data_gnt_o,
    input  logic                   data_we_i,
    input  logic [DataWidth/8-1:0] data_be_i,
    input  logic [AddrWidth-1:0]   data_addr_i,
    input  logic [DataWidth-1:0]   data_wdata_i,
    output logic                   data_rvalid_o,
    output logic [DataWidth-1:0]   data_rdata_o,
    output logic                   data_err_o,
    output reg_req_t               reg_req_o,
    input  reg_rsp_t               reg_rsp_i,
    output logic                   busy_o,
    output logic                   timeout_o
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_e;

    state_e                 r_state;
    state_e                 w_next;

    logic [AddrWidth-1:0]   r_addr;
    logic                   r_we;
    logic [DataWidth/8-1:0] r_be;
    logic [DataWidth-1:0]   r_wdata;
    logic [DataWidth-1:0]   r_rdata;
    logic                   r_err;

    logic w_accept;
    logic w_cap_rsp;
    logic w_cap_tmo;
    logic w_tmo_en;
    logic w_expired;
    logic w_valid;

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and handshake decode; grant never looks at the regbus side.
    always_comb begin
        w_next        = r_state;
        data_gnt_o    = 1'b0;
        data_rvalid_o = 1'b0;
        busy_o        = 1'b0;
        timeout_o     = 1'b0;
        w_valid       = 1'b0;
        w_accept      = 1'b0;
        w_cap_rsp     = 1'b0;
        w_cap_tmo     = 1'b0;
        w_tmo_en      = 1'b0;
        case (r_state)
            IDLE: begin
                data_gnt_o = data_req_i;
                if (data_req_i) begin
                    w_accept = 1'b1;
                    w_next   = BUSY;
                end
            end
            BUSY: begin
                busy_o  = 1'b1;
                w_valid = 1'b1;
                if (reg_rsp_i.ready) begin
                    w_cap_rsp = 1'b1;
                    w_next    = RESP;
                end else begin
                    w_tmo_en = 1'b1;
                    if (w_expired) begin
                        w_cap_tmo = 1'b1;
                        timeout_o = 1'b1;
                        w_next    = RESP;
                    end
                end
            end
            RESP: begin
                busy_o        = 1'b1;
                data_rvalid_o = 1'b1;
                data_gnt_o    = data_req_i;
                if (data_req_i) begin
                    w_accept = 1'b1;
                    w_next   = BUSY;
                end else begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Request latch and response capture.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_be    <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr  <= data_addr_i;
                r_we    <= data_we_i;
                r_be    <= data_be_i;
                r_wdata <= data_wdata_i;
            end
            if (w_cap_rsp) begin
                r_rdata <= r_we ? '0 : reg_rsp_i.rdata;
                r_err   <= reg_rsp_i.error;
            end else if (w_cap_tmo) begin
                r_rdata <= DataWidth'(BridgeErrVal);
                r_err   <= 1'b1;
            end
        end
    end

    safety_obi_reg_bridge_tmo #(
        .TimeoutCycles(TimeoutCycles)
    ) u_tmo (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clear_i  (w_accept),
        .enable_i (w_tmo_en),
        .expired_o(w_expired)
    );

    // Regbus request: only valid follows the state, the rest stays latched.
    always_comb begin
        reg_req_o       = '0;
        reg_req_o.addr  = r_addr;
        reg_req_o.write = r_we;
        reg_req_o.wdata = r_wdata;
        reg_req_o.wstrb = r_be;
        reg_req_o.valid = w_valid;
    end

    assign data_rdata_o = r_rdata;
    assign data_err_o   = r_err;

endmodule

// File: tb/tb_safety_obi_reg_bridge.sv
// Directed plus randomized bench for safety_obi_reg_bridge with a short timeout.
module tb_safety_obi_reg_bridge;
    import safety_island_pkg::*;

    localparam int unsigned N = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            data_req;
    logic            data_gnt;
    logic            data_we;
    logic [3:0]      data_be;
    logic [31:0]     data_addr;
    logic [31:0]     data_wdata;
    logic            data_rvalid;
    logic [31:0]     data_rdata;
    logic            data_err;
    bridge_reg_req_t reg_req;
    bridge_reg_rsp_t reg_rsp;
    logic            busy;
    logic            timeout;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    safety_obi_reg_bridge #(
        .AddrWidth    (32),
        .DataWidth    (32),
        .TimeoutCycles(N),
        .reg_req_t    (bridge_reg_req_t),
        .reg_rsp_t    (bridge_reg_rsp_t)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .data_req_i   (data_req),
        .data_gnt_o   (data_gnt),
        .data_we_i    (data_we),
        .data_be_i    (data_be),
        .data_addr_i  (data_addr),
        .data_wdata_i (data_wdata),
        .data_rvalid_o(data_rvalid),
        .data_rdata_o (data_rdata),
        .data_err_o   (data_err),
        .reg_req_o    (reg_req),
        .reg_rsp_i    (reg_rsp),
        .busy_o       (busy),
        .timeout_o    (timeout)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One isolated transaction. The peripheral answers after `waits` wait
    // cycles; the expected outcome follows from the timeout rule alone:
    // ready in BUSY cycle waits+1 is honoured while waits+1 <= N.
    task automatic do_txn(input logic we, input logic [3:0] be, input logic [31:0] addr,
                          input logic [31:0] wdata, input int unsigned waits,
                          input logic perr, input logic [31:0] prdata);
        logic        tmo;
        int unsigned busy_n;
        logic [31:0] exp_rdata;
        logic        exp_err;
        tmo       = (waits + 1 > N);
        busy_n    = tmo ? N : waits + 1;
        exp_rdata = tmo ? 32'hBADCAB1E : (we ? 32'h0 : prdata);
        exp_err   = tmo ? 1'b1 : perr;

        data_req = 1'b1; data_we = we; data_be = be; data_addr = addr; data_wdata = wdata;
        reg_rsp  = '0;
        @(negedge clk);
        chk("gnt_req", data_gnt, 1'b1);
        chk("rvalid_req", data_rvalid, 1'b0);
        next_cycle();
        // scramble the OBI inputs: the bridge must use its latched copy
        data_req = 1'b0; data_we = ~we; data_be = ~be; data_addr = $urandom; data_wdata = $urandom;

        for (int unsigned b = 1; b <= busy_n; b++) begin
            reg_rsp.ready = (b == waits + 1);
            reg_rsp.error = perr;
            reg_rsp.rdata = prdata;
            @(negedge clk);
            chk("gnt_busy", data_gnt, 1'b0);
            chk("busy_busy", busy, 1'b1);
            chk("rvalid_busy", data_rvalid, 1'b0);
            chk("valid_busy", reg_req.valid, 1'b1);
            chk("write_busy", reg_req.write, we);
            chk("wstrb_busy", reg_req.wstrb, be);
            chk("addr_busy", reg_req.addr, addr);
            chk("wdata_busy", reg_req.wdata, wdata);
            chk("timeout_busy", timeout, tmo && (b == N));
            next_cycle();
            reg_rsp = '0;
        end

        if (tmo) begin
            reg_rsp.ready = 1'b1; reg_rsp.rdata = $urandom; reg_rsp.error = 1'b0;
        end
        @(negedge clk);
        chk("rvalid_resp", data_rvalid, 1'b1);
        chk("rdata_resp", data_rdata, exp_rdata);
        chk("err_resp", data_err, exp_err);
        chk("valid_resp", reg_req.valid, 1'b0);
        chk("timeout_resp", timeout, 1'b0);
        next_cycle();
        @(negedge clk);
        chk("rvalid_idle", data_rvalid, 1'b0);
        chk("busy_idle", busy, 1'b0);
        chk("valid_idle", reg_req.valid, 1'b0);
        chk("addr_idle", reg_req.addr, addr);
        next_cycle();
        reg_rsp = '0;
    endtask

    logic [31:0] b2b_data [4];
    logic [31:0] b2b_addr [4];

    initial begin
        rst = 1'b1; data_req = 1'b0; data_we = 1'b0; data_be = '0;
        data_addr = '0; data_wdata = '0; reg_rsp = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_gnt", data_gnt, 1'b0);
        chk("rst_rvalid", data_rvalid, 1'b0);
        chk("rst_rdata", data_rdata, 32'h0);
        chk("rst_err", data_err, 1'b0);
        chk("rst_reg_req", reg_req, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_timeout", timeout, 1'b0);
        next_cycle();

        // zero-wait read, waited write, hung peripheral, error, ready on timeout cycle
        do_txn(1'b0, 4'hF, 32'h0020_0000, 32'h0, 0, 1'b0, 32'h1234_5678);
        do_txn(1'b1, 4'b0011, 32'h0020_1004, 32'hCAFE_F00D, 3, 1'b0, 32'h5555_AAAA);
        do_txn(1'b0, 4'hF, 32'h0020_2000, 32'h0, 40, 1'b0, 32'h0);
        do_txn(1'b0, 4'hF, 32'h0020_3000, 32'h0, 2, 1'b1, 32'h0BAD_0BAD);
        do_txn(1'b0, 4'hF, 32'h0020_4000, 32'h0, N - 1, 1'b0, 32'h7777_1111);

        // four back-to-back zero-wait reads with req held high
        for (int i = 0; i < 4; i++) begin
            b2b_data[i] = $urandom;
            b2b_addr[i] = $urandom;
        end
        for (int c = 0; c <= 8; c++) begin
            data_req = (c <= 6);
            data_we  = 1'b0;
            data_be  = 4'hF;
            if (c % 2 == 0 && c <= 6) data_addr = b2b_addr[c/2];
            reg_rsp.ready = 1'b1;
            reg_rsp.error = 1'b0;
            reg_rsp.rdata = (c % 2 == 1) ? b2b_data[c/2] : 32'hDEAD_DEAD;
            @(negedge clk);
            chk("b2b_gnt", data_gnt, (c % 2 == 0) && (c <= 6));
            chk("b2b_rvalid", data_rvalid, (c % 2 == 0) && (c >= 2));
            chk("b2b_busy", busy, c >= 1);
            if (c % 2 == 0 && c >= 2) chk("b2b_rdata", data_rdata, b2b_data[c/2 - 1]);
            if (c % 2 == 1) chk("b2b_addr", reg_req.addr, b2b_addr[c/2]);
            next_cycle();
        end
        data_req = 1'b0; reg_rsp = '0;
        @(negedge clk);
        chk("b2b_end_busy", busy, 1'b0);
        next_cycle();

        // reset in the middle of a waited transaction
        data_req = 1'b1; data_we = 1'b1; data_be = 4'hF; data_addr = 32'h0020_5000; data_wdata = 32'h1;
        next_cycle();
        data_req = 1'b0;
        @(negedge clk);
        chk("mid_busy", busy, 1'b1);
        next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("mrst_rvalid", data_rvalid, 1'b0);
        chk("mrst_gnt", data_gnt, 1'b0);
        chk("mrst_reg_req", reg_req, '0);
        chk("mrst_busy", busy, 1'b0);
        chk("mrst_rdata", data_rdata, 32'h0);
        chk("mrst_err", data_err, 1'b0);
        next_cycle();
        @(negedge clk);
        chk("mrst_rvalid2", data_rvalid, 1'b0);
        next_cycle();
        do_txn(1'b0, 4'hF, 32'h0020_6000, 32'h0, 1, 1'b0, 32'hA5A5_5A5A);

        // randomized transactions, some beyond the timeout
        for (int t = 0; t < 24; t++) begin
            do_txn(1'($urandom_range(0, 1)), 4'($urandom), $urandom, $urandom,
                   $urandom_range(0, 11), 1'($urandom_range(0, 1)), $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
